// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent down/up timers with a shared prescaler
// and a small word-addressed register file.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous, active-high
//   addr     - byte address; addr[3:2] register, addr[6:4] channel
//   we       - write strobe
//   din      - write data
//   dout     - combinational read data for addr
//   irq_vec  - per-channel interrupt (pending & IM)
//   irq      - OR of irq_vec
//
// Per-channel registers (addr[3:2]):
//   0 CTRL   {IM, MODE[1:0], EN}
//   1 PRESET WIDTH bits
//   2 COUNT  read-only
//   3 STATUS bit0 pending, write 1 to clear
//
// Channel FSM:
//   state  | meaning
//   S_IDLE | stopped, COUNT holds; EN=1 starts a run
//   S_LOAD | COUNT <- PRESET (down modes) or 0 (up mode)
//   S_CNT  | counting on prescaler ticks; EN=0 stops with COUNT frozen
//   S_DONE | expired this cycle; reload (MODE 01) or clear EN and stop
module multi_timer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic                we,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  output logic [CHANNELS-1:0] irq_vec,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // 17 bits covers PRESCALE up to 2^16.
  localparam int PW = 17;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [31:0]   rd_val [CHANNELS];
  logic          unused_bits;

  assign unused_bits = ^{addr[31:7], addr[1:0], din};

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state, state_nxt;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] preset, count, count_nxt;
    logic [WIDTH:0]   count_inc;
    logic             pending, pend_set, en_clr;
    logic             sel, wr_ctrl, wr_preset, clr_pend;
    logic             en_eff, mode_up, mode_reload;
    logic [31:0]      rv;

    assign sel         = (addr[6:4] == 3'(g));
    assign wr_ctrl     = we && sel && (addr[3:2] == 2'd0);
    assign wr_preset   = we && sel && (addr[3:2] == 2'd1);
    assign clr_pend    = we && sel && (addr[3:2] == 2'd3) && din[0];
    // IDLE looks at the EN being written this cycle so LOAD follows the
    // enabling write directly.
    assign en_eff      = wr_ctrl ? din[0] : ctrl[0];
    assign mode_up     = (ctrl[2:1] == 2'b10);
    assign mode_reload = (ctrl[2:1] == 2'b01);
    // One extra bit so PRESET = all-ones still terminates in up mode.
    assign count_inc   = {1'b0, count} + (WIDTH+1)'(1);

    always_comb begin
      state_nxt = state;
      count_nxt = count;
      pend_set  = 1'b0;
      en_clr    = 1'b0;
      case (state)
        S_IDLE: begin
          if (en_eff) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          count_nxt = mode_up ? '0 : preset;
          state_nxt = S_CNT;
        end
        S_CNT: begin
          if (!ctrl[0]) begin
            state_nxt = S_IDLE;
          end else if (tick) begin
            if (mode_up) begin
              if (count_inc >= {1'b0, preset}) begin
                count_nxt = preset;
                pend_set  = 1'b1;
                state_nxt = S_DONE;
              end else begin
                count_nxt = count_inc[WIDTH-1:0];
              end
            end else begin
              if (count <= WIDTH'(1)) begin
                count_nxt = '0;
                pend_set  = 1'b1;
                state_nxt = S_DONE;
              end else begin
                count_nxt = count - WIDTH'(1);
              end
            end
          end
        end
        S_DONE: begin
          if (mode_reload) begin
            state_nxt = S_LOAD;
          end else begin
            en_clr    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= S_IDLE;
        ctrl    <= '0;
        preset  <= '0;
        count   <= '0;
        pending <= 1'b0;
      end else begin
        state <= state_nxt;
        count <= count_nxt;
        // CPU write wins over the end-of-run EN clear.
        if (wr_ctrl)     ctrl    <= din[3:0];
        else if (en_clr) ctrl[0] <= 1'b0;
        if (wr_preset)   preset  <= din[WIDTH-1:0];
        // Hardware set wins over a coincident write-1-to-clear.
        pending <= pend_set | (pending & ~clr_pend);
      end
    end

    always_comb begin
      rv = '0;
      case (addr[3:2])
        2'd0:    rv[3:0]       = ctrl;
        2'd1:    rv[WIDTH-1:0] = preset;
        2'd2:    rv[WIDTH-1:0] = count;
        default: rv[0]         = pending;
      endcase
    end

    assign rd_val[g]  = rv;
    assign irq_vec[g] = pending & ctrl[3];
  end

  // Channel indices without a channel fall through to zero.
  always_comb begin
    dout = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr[6:4] == 3'(c)) dout = rd_val[c];
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_b [2];
  logic        we_b   [2];
  logic [31:0] din_b  [2];
  logic [31:0] dout_b [2];
  logic [1:0]  irqv_b [2];
  logic        irq_b  [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          gc;

  always #5 clk = ~clk;

  // dut index 0: PRESCALE=1, WIDTH=32; dut index 1: PRESCALE=4, WIDTH=12
  multi_timer #(.CHANNELS(2), .WIDTH(32), .PRESCALE(1)) dut_p1 (
    .clk(clk), .reset(reset), .addr(addr_b[0]), .we(we_b[0]), .din(din_b[0]),
    .dout(dout_b[0]), .irq_vec(irqv_b[0]), .irq(irq_b[0]));

  multi_timer #(.CHANNELS(2), .WIDTH(12), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(reset), .addr(addr_b[1]), .we(we_b[1]), .din(din_b[1]),
    .dout(dout_b[1]), .irq_vec(irqv_b[1]), .irq(irq_b[1]));

  // Cycle number since reset release; the prescaler ticks when gc % P == P-1.
  always @(posedge clk) begin
    if (reset) gc <= 0;
    else       gc <= gc + 1;
  end

  function automatic int pres_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int ticks_in(input int a, input int b, input int p);
    int n = 0;
    for (int t = a; t < b; t++) if (t % p == p - 1) n++;
    return n;
  endfunction

  task automatic rd(input int d, input int ch, input int r, output logic [31:0] v);
    logic [2:0] c3;
    logic [1:0] r2;
    c3 = ch[2:0];
    r2 = r[1:0];
    addr_b[d] = {25'd0, c3, r2, 2'b00};
    #1 v = dout_b[d];
  endtask

  task automatic drive_wr(input int d, input int ch, input int r, input logic [31:0] v);
    logic [2:0] c3;
    logic [1:0] r2;
    c3 = ch[2:0];
    r2 = r[1:0];
    addr_b[d] = {25'd0, c3, r2, 2'b00};
    din_b[d]  = v;
    we_b[d]   = 1'b1;
  endtask

  task automatic wr(input int d, input int ch, input int r, input logic [31:0] v);
    @(negedge clk);
    drive_wr(d, ch, r, v);
    @(posedge clk);
    #1 we_b[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      we_b[d] = 1'b0; addr_b[d] = '0; din_b[d] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++)
        for (int r = 0; r < 4; r++) begin
          rd(d, ch, r, v);
          n_cmp++;
          if (v !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_reg d%0d ch%0d r%0d: got %h want 0", d, ch, r, v);
          end
        end
      n_cmp++;
      if (irq_b[d] !== 1'b0 || irqv_b[d] !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_irq d%0d: got irq=%b vec=%b want 0/00", d, irq_b[d], irqv_b[d]);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 0, 32'hFFFF_FFF6);
      rd(d, 0, 0, v);
      n_cmp++;
      if (v !== 32'h6) begin
        n_bad++; $display("FAIL ctrl_reserved d%0d: got %h want 6", d, v);
      end
      wr(d, 1, 1, 32'hFFFF_FFFF);
      rd(d, 1, 1, v);
      n_cmp++;
      if (v !== ((d == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF)) begin
        n_bad++; $display("FAIL preset_width d%0d: got %h", d, v);
      end
      wr(d, 1, 2, 32'h1234);
      rd(d, 1, 2, v);
      n_cmp++;
      if (v !== 32'd0) begin
        n_bad++; $display("FAIL count_ro d%0d: got %h want 0", d, v);
      end
      wr(d, 0, 0, 32'h0);
      wr(d, 1, 1, 32'h0);
    end
  endtask

  task automatic test_oneshot_down();
    logic [31:0] v;
    wr(0, 0, 1, 3);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k >= 2 && k <= 5) begin
        rd(0, 0, 2, v);
        n_cmp++;
        if (v !== 32'(5 - k)) begin
          n_bad++; $display("FAIL down_count k%0d: got %0d want %0d", k, v, 5 - k);
        end
      end
      if (k == 4 || k == 5) begin
        rd(0, 0, 3, v);
        n_cmp++;
        if (v !== 32'(k == 5) || irqv_b[0][0] !== (k == 5)) begin
          n_bad++; $display("FAIL down_pending k%0d: got %0d/%b want %0d", k, v, irqv_b[0][0], k == 5);
        end
      end
      if (k == 6) begin
        rd(0, 0, 0, v);
        n_cmp++;
        if (v !== 32'h8) begin
          n_bad++; $display("FAIL down_en_clear: got %h want 8", v);
        end
      end
      if (k == 0) drive_wr(0, 0, 0, 32'h9);
    end
    wr(0, 0, 3, 1);
    #1;
    n_cmp++;
    if (irq_b[0] !== 1'b0) begin
      n_bad++; $display("FAIL down_w1c: got irq=%b want 0", irq_b[0]);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic        exp;
    wr(0, 1, 1, 2);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k >= 1) begin
        exp = (k >= 4 && k <= 5) || (k >= 8);
        n_cmp++;
        if (irq_b[0] !== exp || irqv_b[0][1] !== exp) begin
          n_bad++; $display("FAIL reload_irq k%0d: got %b want %b", k, irq_b[0], exp);
        end
      end
      if (k == 6) begin
        rd(0, 1, 2, v);
        n_cmp++;
        if (v !== 32'd2) begin
          n_bad++; $display("FAIL reload_count: got %0d want 2", v);
        end
      end
      if (k == 0) drive_wr(0, 1, 0, 32'hB);
      if (k == 5) drive_wr(0, 1, 3, 32'h1);
    end
    wr(0, 1, 0, 0);
    repeat (5) @(negedge clk);
    wr(0, 1, 3, 1);
    #1;
    n_cmp++;
    if (irq_b[0] !== 1'b0) begin
      n_bad++; $display("FAIL reload_stop: got irq=%b want 0", irq_b[0]);
    end
  endtask

  task automatic test_up();
    logic [31:0] v;
    wr(0, 0, 1, 4);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k >= 2 && k <= 6) begin
        rd(0, 0, 2, v);
        n_cmp++;
        if (v !== 32'(k - 2)) begin
          n_bad++; $display("FAIL up_count k%0d: got %0d want %0d", k, v, k - 2);
        end
      end
      if (k == 5 || k == 6) begin
        rd(0, 0, 3, v);
        n_cmp++;
        if (v !== 32'(k == 6)) begin
          n_bad++; $display("FAIL up_pending k%0d: got %0d", k, v);
        end
      end
      if (k == 7) begin
        rd(0, 0, 0, v);
        n_cmp++;
        if (v !== 32'hC) begin
          n_bad++; $display("FAIL up_en_clear: got %h want c", v);
        end
      end
      if (k == 0) drive_wr(0, 0, 0, 32'hD);
    end
    wr(0, 0, 3, 1);
    wr(0, 0, 1, 0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k == 2 || k == 3) begin
        rd(0, 0, 3, v);
        n_cmp++;
        if (v !== 32'(k == 3) || irqv_b[0][0] !== (k == 3)) begin
          n_bad++; $display("FAIL up_zero k%0d: got %0d/%b want %0d", k, v, irqv_b[0][0], k == 3);
        end
      end
      if (k == 0) drive_wr(0, 0, 0, 32'hD);
    end
    wr(0, 0, 3, 1);
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    int          guard = 0;
    wr(1, 0, 1, 2);
    @(negedge clk);
    while (gc % 4 != 2 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 8) begin
      n_bad++; $display("FAIL pre_align: got guard %0d want < 8", guard);
    end
    drive_wr(1, 0, 0, 32'h1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      we_b[1] = 1'b0;
      if (k == 5 || k == 6 || k == 7 || k == 9 || k == 10) begin
        rd(1, 0, 2, v);
        n_cmp++;
        if (v !== ((k == 5) ? 32'd2 : (k == 10) ? 32'd0 : 32'd1)) begin
          n_bad++; $display("FAIL pre_count k%0d: got %0d", k, v);
        end
      end
      if (k == 9 || k == 10) begin
        rd(1, 0, 3, v);
        n_cmp++;
        if (v !== 32'(k == 10)) begin
          n_bad++; $display("FAIL pre_expiry k%0d: got %0d want %0d", k, v, k == 10);
        end
      end
      if (k == 11) begin
        rd(1, 0, 0, v);
        n_cmp++;
        if (v !== 32'h0) begin
          n_bad++; $display("FAIL pre_en_clear: got %h want 0", v);
        end
      end
      if (k == 6) drive_wr(1, 0, 1, 32'd9);
    end
    wr(1, 0, 3, 1);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      we_b[1] = 1'b0;
      if (k == 2) begin
        rd(1, 0, 2, v);
        n_cmp++;
        if (v !== 32'd9) begin
          n_bad++; $display("FAIL pre_new_preset: got %0d want 9", v);
        end
      end
      if (k == 0) drive_wr(1, 0, 0, 32'h1);
    end
    wr(1, 0, 0, 0);
    repeat (4) @(negedge clk);
    wr(1, 0, 3, 1);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] v;
    wr(0, 0, 1, 2);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k >= 3) begin
        rd(0, 0, 3, v);
        n_cmp++;
        if (v !== 32'(k >= 4)) begin
          n_bad++; $display("FAIL w1c_collide k%0d: got %0d want %0d", k, v, k >= 4);
        end
      end
      if (k == 0) drive_wr(0, 0, 0, 32'h9);
      if (k == 3) drive_wr(0, 0, 3, 32'h1);
    end
    wr(0, 0, 3, 1);
    wr(0, 5, 0, 32'hF);
    wr(0, 5, 1, 32'h55);
    rd(0, 5, 0, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_bad++; $display("FAIL ch5_ctrl: got %h want 0", v);
    end
    rd(0, 5, 1, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_bad++; $display("FAIL ch5_preset: got %h want 0", v);
    end
    rd(0, 1, 0, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_bad++; $display("FAIL ch5_alias_ctrl: got %h want 0", v);
    end
    rd(0, 1, 1, v);
    n_cmp++;
    if (v !== 32'd2) begin
      n_bad++; $display("FAIL ch5_alias_preset: got %h want 2", v);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (irq_b[0] !== 1'b0) begin
      n_bad++; $display("FAIL ch5_irq: got %b want 0", irq_b[0]);
    end
  endtask

  task automatic test_random_oneshot();
    logic [31:0] v;
    logic [1:0]  mode;
    logic        im, pend;
    int d, ch, n, p, c0, e, need, tk, last, t, nt, expc;
    for (int it = 0; it < 12; it++) begin
      d    = $urandom_range(0, 1);
      ch   = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       mode = 2'b00;
        1:       mode = 2'b10;
        default: mode = 2'b11;
      endcase
      n    = $urandom_range(0, (d == 0) ? 6 : 3);
      im   = 1'($urandom_range(0, 1));
      p    = pres_of(d);
      wr(d, ch, 1, 32'(n));
      wr(d, ch, 3, 1);
      @(negedge clk);
      c0 = gc;
      drive_wr(d, ch, 0, {28'd0, im, mode, 1'b1});
      e    = c0 + 2;
      need = (n == 0) ? 1 : n;
      tk   = e;
      while (ticks_in(e, tk + 1, p) < need && tk < e + 100) tk++;
      last = tk + 2 - c0;
      for (int k = 1; k <= last; k++) begin
        @(negedge clk);
        we_b[d] = 1'b0;
        t = c0 + k;
        pend = (t >= tk + 1);
        if (t >= e) begin
          nt = ticks_in(e, t, p);
          if (t >= tk + 1) expc = (mode == 2'b10) ? n : 0;
          else             expc = (mode == 2'b10) ? nt : n - nt;
          rd(d, ch, 2, v);
          n_cmp++;
          if (v !== 32'(expc)) begin
            n_bad++;
            $display("FAIL rnd_count it%0d d%0d ch%0d m%0d n%0d k%0d: got %0d want %0d", it, d, ch, mode, n, k, v, expc);
          end
        end
        rd(d, ch, 3, v);
        n_cmp++;
        if (v !== 32'(pend) || irqv_b[d][ch] !== (pend & im)) begin
          n_bad++;
          $display("FAIL rnd_pending it%0d k%0d: got %0d/%b want %0d/%b", it, k, v, irqv_b[d][ch], pend, pend & im);
        end
        if (k == last) begin
          rd(d, ch, 0, v);
          n_cmp++;
          if (v !== {28'd0, im, mode, 1'b0}) begin
            n_bad++; $display("FAIL rnd_ctrl it%0d: got %h", it, v);
          end
        end
      end
      wr(d, ch, 3, 1);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    wr(0, 0, 1, 20);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      we_b[0] = 1'b0;
      if (k == 15) begin
        rd(0, 0, 2, v);
        n_cmp++;
        if (v !== 32'd7) begin
          n_bad++; $display("FAIL rst_mid_count: got %0d want 7", v);
        end
        reset = 1'b1;
      end
      if (k == 16) begin
        for (int ch = 0; ch < 2; ch++)
          for (int r = 0; r < 4; r++) begin
            rd(0, ch, r, v);
            n_cmp++;
            if (v !== 32'd0) begin
              n_bad++; $display("FAIL rst_mid_reg ch%0d r%0d: got %h want 0", ch, r, v);
            end
          end
        n_cmp++;
        if (irq_b[0] !== 1'b0) begin
          n_bad++; $display("FAIL rst_mid_irq: got %b want 0", irq_b[0]);
        end
        reset = 1'b0;
      end
      if (k == 20) begin
        rd(0, 0, 3, v);
        n_cmp++;
        if (v !== 32'd0 || irq_b[0] !== 1'b0) begin
          n_bad++; $display("FAIL rst_mid_after: got %0d/%b want 0/0", v, irq_b[0]);
        end
      end
      if (k == 0) drive_wr(0, 0, 0, 32'h9);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_oneshot_down();
    test_autoreload();
    test_up();
    test_prescale();
    test_w1c_collision();
    test_random_oneshot();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
